cardinal_nic_fifo: RTL and testbench

CARDINAL_NIC_FIFO -- requirements
Module: cardinal_nic_fifo

---
 rtl/cardinal_nic_fifo.sv | 160 ++++++++++++++++
 tb/tb_cardinal_nic_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic_fifo.sv
`default_nettype none
// ============================================================================
// cardinal_nic_fifo : CPU <-> router NIC with one IN and one OUT circular FIFO
// Rev 1.0
// ============================================================================
module cardinal_nic_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int POL_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:1]        addr_nic,
   input  logic [0:DATA_W-1] d_in,
   output logic [0:DATA_W-1] d_out,
   input  logic              nicEn,
   input  logic              nicWrEn,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [0:DATA_W-1] net_di,
   output logic              net_so,
   input  logic              net_ro,
   output logic [0:DATA_W-1] net_do,
   input  logic              net_polarity
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ADDR_IN_DATA  = 2'd0;
   localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
   localparam logic [1:0] ADDR_OUT_DATA = 2'd2;
   localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Storage carries no reset; pointers and counts alone define validity.
   logic [0:DATA_W-1] in_mem_q  [DEPTH];
   logic [0:DATA_W-1] out_mem_q [DEPTH];

   logic [PTR_W-1:0] in_rd_q,  in_rd_d,  in_wr_q,  in_wr_d;
   logic [PTR_W-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic             ovf_q, ovf_d;
   logic             rdy_q, rdy_d;

   logic             cpu_rd, cpu_wr;
   logic             in_nonempty, out_nonempty, out_full;
   logic             in_push, in_pop, out_push, out_pop;
   logic             out_wr_req, ovf_drop, out_stat_rd;
   logic [0:DATA_W-1] in_head;

   // Outputs depend only on registered state (plus read-side CPU selects).
   always_comb begin
      cpu_rd       = nicEn && !nicWrEn;
      cpu_wr       = nicEn && nicWrEn;
      in_nonempty  = (in_cnt_q != '0);
      out_nonempty = (out_cnt_q != '0);
      out_full     = (out_cnt_q == CNT_FULL);

      in_head = '0;
      if (in_nonempty) begin
         in_head = in_mem_q[in_rd_q];
      end

      net_do = '0;
      if (out_nonempty) begin
         net_do = out_mem_q[out_rd_q];
      end

      // rdy_q holds net_ri low through reset and until the first clean edge.
      net_ri = rdy_q && (in_cnt_q != CNT_FULL);
      net_so = out_nonempty && ((POL_EN == 0) || (net_do[0] == net_polarity));

      d_out = '0;
      if (cpu_rd) begin
         case (addr_nic)
            ADDR_IN_DATA:  d_out = in_head;
            ADDR_IN_STAT:  d_out = DATA_W'({1'b0, in_cnt_q, in_nonempty});
            ADDR_OUT_STAT: d_out = DATA_W'({ovf_q, out_cnt_q, out_full});
            default:       d_out = '0;
         endcase
      end
   end

   always_comb begin
      in_push     = net_si && net_ri;
      in_pop      = cpu_rd && (addr_nic == ADDR_IN_DATA) && in_nonempty;
      out_pop     = net_so && net_ro;
      out_wr_req  = cpu_wr && (addr_nic == ADDR_OUT_DATA);
      // A full OUT still accepts a write when the router drains it on the same edge.
      out_push    = out_wr_req && (!out_full || out_pop);
      ovf_drop    = out_wr_req && !out_push;
      out_stat_rd = cpu_rd && (addr_nic == ADDR_OUT_STAT);

      in_rd_d   = in_pop   ? in_rd_q  + PTR_ONE : in_rd_q;
      in_wr_d   = in_push  ? in_wr_q  + PTR_ONE : in_wr_q;
      out_rd_d  = out_pop  ? out_rd_q + PTR_ONE : out_rd_q;
      out_wr_d  = out_push ? out_wr_q + PTR_ONE : out_wr_q;

      in_cnt_d = in_cnt_q;
      if (in_push && !in_pop) begin
         in_cnt_d = in_cnt_q + CNT_ONE;
      end else if (!in_push && in_pop) begin
         in_cnt_d = in_cnt_q - CNT_ONE;
      end

      out_cnt_d = out_cnt_q;
      if (out_push && !out_pop) begin
         out_cnt_d = out_cnt_q + CNT_ONE;
      end else if (!out_push && out_pop) begin
         out_cnt_d = out_cnt_q - CNT_ONE;
      end

      // Sticky overflow: a drop on the same edge as a status read wins.
      ovf_d = ovf_q;
      if (ovf_drop) begin
         ovf_d = 1'b1;
      end else if (out_stat_rd) begin
         ovf_d = 1'b0;
      end

      rdy_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_rd_q   <= '0;
         in_wr_q   <= '0;
         out_rd_q  <= '0;
         out_wr_q  <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         ovf_q     <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         in_rd_q   <= in_rd_d;
         in_wr_q   <= in_wr_d;
         out_rd_q  <= out_rd_d;
         out_wr_q  <= out_wr_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         ovf_q     <= ovf_d;
         rdy_q     <= rdy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_push) begin
         in_mem_q[in_wr_q] <= net_di;
      end
      if (out_push) begin
         out_mem_q[out_wr_q] <= d_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic_fifo.sv
`default_nettype none
// Bench for cardinal_nic_fifo: queue-based reference model checked every
// falling edge, plus literal expectations for the directed scenarios.
module tb_cardinal_nic_fifo;

   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int SH    = $clog2(DEPTH) + 2;   // ovf position in a status word

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    addr_nic = '0;
   logic [DW-1:0] d_in = '0;
   logic [DW-1:0] d_out;
   logic          nicEn = 1'b0;
   logic          nicWrEn = 1'b0;
   logic          net_si = 1'b0;
   logic          net_ri;
   logic [DW-1:0] net_di = '0;
   logic          net_so;
   logic          net_ro = 1'b0;
   logic [DW-1:0] net_do;
   logic          net_polarity = 1'b0;
   bit            pol_run = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] in_q[$];
   logic [DW-1:0] out_q[$];
   logic [DW:0]   sent[$];
   bit            m_ovf = 1'b0;
   bit            m_rdy = 1'b0;

   cardinal_nic_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .POL_EN(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr_nic     (addr_nic),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicWrEn      (nicWrEn),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs come from queue sizes/fronts, then the
   // queues advance as the coming rising edge will.
   logic [DW-1:0] e_do, e_dout;
   bit            e_so, e_ri, rd, wr2, ipush, ipop, opop, acc;

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_ri", net_ri, 0);
         chk("rst_so", net_so, 0);
         chk("rst_do", net_do, 0);
         chk("rst_dout", d_out, 0);
         in_q.delete();
         out_q.delete();
         m_ovf = 1'b0;
         m_rdy = 1'b0;
      end else begin
         e_do = (out_q.size() > 0) ? out_q[0] : '0;
         e_so = (out_q.size() > 0) && (e_do[DW-1] == net_polarity);
         e_ri = m_rdy && (in_q.size() < DEPTH);
         rd   = nicEn && !nicWrEn;
         e_dout = '0;
         if (rd) begin
            case (addr_nic)
               2'd0: e_dout = (in_q.size() > 0) ? in_q[0] : '0;
               2'd1: e_dout = DW'(in_q.size() * 2 + ((in_q.size() > 0) ? 1 : 0));
               2'd3: e_dout = DW'((m_ovf ? (1 << SH) : 0) + out_q.size() * 2
                                  + ((out_q.size() == DEPTH) ? 1 : 0));
               default: e_dout = '0;
            endcase
         end
         chk("net_ri", net_ri, e_ri);
         chk("net_so", net_so, e_so);
         chk("net_do", net_do, e_do);
         chk("d_out", d_out, e_dout);

         wr2   = nicEn && nicWrEn && (addr_nic == 2'd2);
         ipush = net_si && e_ri;
         ipop  = rd && (addr_nic == 2'd0) && (in_q.size() > 0);
         opop  = e_so && net_ro;
         acc   = wr2 && ((out_q.size() < DEPTH) || opop);
         if (ipop)  void'(in_q.pop_front());
         if (ipush) in_q.push_back(net_di);
         if (opop) begin
            sent.push_back({net_polarity, out_q[0]});
            void'(out_q.pop_front());
         end
         if (acc) out_q.push_back(d_in);
         if (wr2 && !acc)                    m_ovf = 1'b1;
         else if (rd && addr_nic == 2'd3)    m_ovf = 1'b0;
         m_rdy = 1'b1;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (pol_run) net_polarity = ~net_polarity;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu(input logic en, input logic wr, input logic [1:0] a, input logic [DW-1:0] d);
      nicEn   = en;
      nicWrEn = wr;
      addr_nic = a;
      d_in    = d;
   endtask

   initial begin
      #1 reset = 1'b0;
      tick();
      tick();
      #1 chk("lit_rst_ri", net_ri, 0);
      reset = 1'b1;
      tick();
      #1 chk("lit_ri_after_rst", net_ri, 1);

      // OUT injection gated by polarity, in order
      net_ro  = 1'b1;
      pol_run = 1'b1;
      cpu(1, 1, 2, 64'h0000_0000_0000_00A1);
      tick();
      cpu(1, 1, 2, 64'h8000_0000_0000_00B2);
      tick();
      cpu(0, 0, 0, '0);
      repeat (6) tick();
      chk("lit_sent_n", DW'(sent.size()), 2);
      chk("lit_sent0", (sent.size() > 0) ? sent[0] : '1, {1'b0, 64'h0000_0000_0000_00A1});
      chk("lit_sent1", (sent.size() > 1) ? sent[1] : '1, {1'b1, 64'h8000_0000_0000_00B2});
      pol_run = 1'b0;
      net_polarity = 1'b0;
      net_ro = 1'b0;

      // five writes into a stalled OUT: one drop, sticky ovf then clear-on-read
      for (int i = 0; i < 5; i++) begin
         cpu(1, 1, 2, 64'h100 + DW'(i));
         tick();
      end
      cpu(1, 0, 3, '0);
      #1 chk("lit_out_stat_ovf", d_out, 64'h19);
      tick();
      #1 chk("lit_out_stat_clr", d_out, 64'h09);

      // full OUT: write on the same edge as a router pop is accepted
      net_ro = 1'b1;
      cpu(1, 1, 2, 64'h1FF);
      #1 chk("lit_full_so", net_so, 1);
      tick();
      net_ro = 1'b0;
      cpu(1, 0, 3, '0);
      #1 chk("lit_full_stat", d_out, 64'h09);
      tick();
      cpu(0, 0, 0, '0);
      net_ro = 1'b1;
      repeat (5) tick();
      net_ro = 1'b0;
      cpu(1, 0, 3, '0);
      #1 chk("lit_out_empty", d_out, 0);
      tick();
      cpu(0, 0, 0, '0);

      // router fills IN; a 5th send is refused
      net_si = 1'b1;
      for (int i = 0; i < 4; i++) begin
         net_di = 64'hC0 + DW'(i);
         tick();
      end
      #1 chk("lit_in_full_ri", net_ri, 0);
      net_di = 64'hDEAD;
      tick();
      net_si = 1'b0;
      cpu(1, 0, 1, '0);
      #1 chk("lit_in_stat", d_out, 64'h09);
      cpu(1, 0, 0, '0);
      #1 chk("lit_in_head", d_out, 64'hC0);
      repeat (4) tick();
      cpu(0, 0, 0, '0);

      // streaming push/pop through IN with pointer wrap
      net_si = 1'b1;
      net_di = 64'hE0;
      cpu(1, 0, 0, '0);
      #1 chk("lit_empty_rd", d_out, 0);
      tick();
      for (int i = 1; i <= 10; i++) begin
         net_di = 64'hE0 + DW'(i);
         tick();
      end
      net_si = 1'b0;
      tick();
      cpu(1, 0, 1, '0);
      #1 chk("lit_in_cnt0", d_out, 0);
      tick();
      cpu(0, 0, 0, '0);

      // reset with OUT holding three packets
      for (int i = 0; i < 3; i++) begin
         cpu(1, 1, 2, 64'h300 + DW'(i));
         tick();
      end
      cpu(0, 0, 0, '0);
      #1 chk("lit_so_pre_rst", net_so, 1);
      #1 reset = 1'b0;
      #1 chk("lit_so_rst", net_so, 0);
      chk("lit_do_rst", net_do, 0);
      cpu(1, 1, 2, 64'hBAD);
      net_si = 1'b1;
      net_di = 64'hBEEF;
      tick();
      tick();
      reset = 1'b1;
      net_si = 1'b0;
      cpu(1, 0, 3, '0);
      #1 chk("lit_stat_after_rst", d_out, 0);
      chk("lit_ri_release", net_ri, 0);
      tick();
      #1 chk("lit_ri_rise", net_ri, 1);
      cpu(0, 0, 0, '0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
